// File: rtl/i2c_eeprom_target.sv
// i2c_eeprom_target: I2C target exposing a 256 x 8 EEPROM-style memory.
// Address 0x50 by default (0xA0 write / 0xA1 read). A write transaction
// loads the word pointer from the first byte and stores later bytes at
// successive addresses. A read transaction returns bytes starting at the
// current pointer. The pointer wraps from 0xFF to 0x00.
// scl_i/sda_i are asynchronous and pass through SCL_SYNC flops. All bus
// events are detected on the synchronized copies.
// Optional feature: define I2C_EEPROM_WP_EN to add a write-protect input
// 'wp'. When wp is high, every data byte is NACKed and the write is dropped.
// The word pointer still advances.

module i2c_eeprom_target #(
  parameter logic [6:0]  DEV_ADDR = 7'h50,
  parameter int unsigned SCL_SYNC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
`ifdef I2C_EEPROM_WP_EN
  input  logic       wp,
`endif
  output logic       sda_oe,
  output logic       busy,
  output logic       wr_pulse,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data
);

  typedef enum logic [3:0] {
    IDLE,
    DEV,
    DEV_ACK,
    WADDR,
    WADDR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RACK
  } state_e;

  // Synchronizers and previous-sample flops used for edge detection.
  logic [SCL_SYNC-1:0] scl_sync_q, scl_sync_d;
  logic [SCL_SYNC-1:0] sda_sync_q, sda_sync_d;
  logic                scl_prev_q, scl_prev_d;
  logic                sda_prev_q, sda_prev_d;

  // Protocol state.
  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] ptr_q, ptr_d;
  logic       rw_q, rw_d;
  logic       ack_phase_q, ack_phase_d;  // 0: waiting to drive, 1: driving
  logic       ack_en_q, ack_en_d;        // pull SDA low in the coming ACK slot
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic       wr_pulse_q, wr_pulse_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;

  // Memory and its write strobe.
  logic [7:0] mem [256];
  logic       mem_we;
  logic [7:0] rd_byte;

  logic scl_s, sda_s;
  logic scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rx_byte;
  logic wp_active;

`ifdef I2C_EEPROM_WP_EN
  assign wp_active = wp;
`else
  assign wp_active = 1'b0;
`endif

  assign scl_s   = scl_sync_q[SCL_SYNC-1];
  assign sda_s   = sda_sync_q[SCL_SYNC-1];
  assign rd_byte = mem[ptr_q];
  assign rx_byte = {shift_q[6:0], sda_s};

  // Bus event decode from synchronized samples. START and STOP need SCL high on two consecutive samples.
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  // Synchronizer shift and edge-history next values.
  always_comb begin
    scl_sync_d = {scl_sync_q[SCL_SYNC-2:0], scl_i};
    sda_sync_d = {sda_sync_q[SCL_SYNC-2:0], sda_i};
    scl_prev_d = scl_s;
    sda_prev_d = sda_s;
  end

  // Protocol FSM: next state, pointer, shift register, SDA drive and write strobe.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    ack_phase_d = ack_phase_q;
    ack_en_d    = ack_en_q;
    sda_oe_d    = sda_oe_q;
    wr_pulse_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    mem_we      = 1'b0;

    if (stop_det) begin
      // A partial byte in shift_q is discarded, so nothing is written.
      state_d     = IDLE;
      sda_oe_d    = 1'b0;
      ack_phase_d = 1'b0;
    end else if (start_det) begin
      // START and repeated START both restart address decode. ptr is kept.
      state_d     = DEV;
      bit_cnt_d   = 3'd7;
      sda_oe_d    = 1'b0;
      ack_phase_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
        end

        DEV: begin
          if (scl_rise) begin
            shift_d = rx_byte;
            if (bit_cnt_q == 3'd0) begin
              if (rx_byte[7:1] == DEV_ADDR) begin
                state_d  = DEV_ACK;
                rw_d     = rx_byte[0];
                ack_en_d = 1'b1;
              end else begin
                state_d = IDLE;
              end
            end else begin
              bit_cnt_d = bit_cnt_q - 3'd1;
            end
          end
        end

        // The ACK slot runs from the SCL fall that ends bit 0 to the SCL fall that ends the ACK clock.
        DEV_ACK, WADDR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            if (!ack_phase_q) begin
              ack_phase_d = 1'b1;
              sda_oe_d    = ack_en_q;
            end else begin
              ack_phase_d = 1'b0;
              sda_oe_d    = 1'b0;
              bit_cnt_d   = 3'd7;
              if (state_q == DEV_ACK && rw_q) begin
                // Present the MSB of mem[ptr] on this SCL low phase.
                state_d  = RDATA;
                shift_d  = rd_byte;
                sda_oe_d = ~rd_byte[7];
              end else if (state_q == DEV_ACK) begin
                state_d = WADDR;
              end else begin
                state_d = WDATA;
              end
            end
          end
        end

        WADDR: begin
          if (scl_rise) begin
            shift_d = rx_byte;
            if (bit_cnt_q == 3'd0) begin
              ptr_d    = rx_byte;
              state_d  = WADDR_ACK;
              ack_en_d = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q - 3'd1;
            end
          end
        end

        WDATA: begin
          if (scl_rise) begin
            shift_d = rx_byte;
            if (bit_cnt_q == 3'd0) begin
              state_d = WDATA_ACK;
              ptr_d   = ptr_q + 8'd1;
              if (wp_active) begin
                ack_en_d = 1'b0;
              end else begin
                ack_en_d   = 1'b1;
                mem_we     = 1'b1;
                wr_pulse_d = 1'b1;
                wr_addr_d  = ptr_q;
                wr_data_d  = rx_byte;
              end
            end else begin
              bit_cnt_d = bit_cnt_q - 3'd1;
            end
          end
        end

        // Each SCL fall ends one bit. Present the next bit, or release SDA after bit 0.
        RDATA: begin
          if (scl_fall) begin
            if (bit_cnt_q == 3'd0) begin
              sda_oe_d    = 1'b0;
              state_d     = RACK;
              ptr_d       = ptr_q + 8'd1;
              ack_phase_d = 1'b0;
            end else begin
              bit_cnt_d = bit_cnt_q - 3'd1;
              shift_d   = {shift_q[6:0], 1'b0};
              sda_oe_d  = ~shift_q[6];
            end
          end
        end

        // The master's ACK is sampled on SCL rise. On ACK, the next byte starts on the following SCL fall.
        RACK: begin
          if (!ack_phase_q) begin
            if (scl_rise) begin
              if (sda_s) begin
                state_d = IDLE;
              end else begin
                ack_phase_d = 1'b1;
              end
            end
          end else if (scl_fall) begin
            ack_phase_d = 1'b0;
            state_d     = RDATA;
            bit_cnt_d   = 3'd7;
            shift_d     = rd_byte;
            sda_oe_d    = ~rd_byte[7];
          end
        end

        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != IDLE) && (state_d != DEV);
  end

  // Synchronizers reset to 1 so an idle bus is seen right after reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end

  // Protocol state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd7;
      shift_q     <= 8'h00;
      ptr_q       <= 8'h00;
      rw_q        <= 1'b0;
      ack_phase_q <= 1'b0;
      ack_en_q    <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_pulse_q  <= 1'b0;
      wr_addr_q   <= 8'h00;
      wr_data_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      ack_phase_q <= ack_phase_d;
      ack_en_q    <= ack_en_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      wr_pulse_q  <= wr_pulse_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // Memory write port.
  always_ff @(posedge clk) begin
    // NOTE: memory contents have no reset. They must survive rst, and a reset would prevent RAM inference.
    if (mem_we) begin
      mem[ptr_q] <= rx_byte;
    end
  end

  assign sda_oe   = sda_oe_q;
  assign busy     = busy_q;
  assign wr_pulse = wr_pulse_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

endmodule
